// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_map_pkg
//  Purpose  : Shared types and default address-map constants for the
//             mem_map_arb memory-map arbiter/decoder and its decode block.
//  Contents : state_t  - arbiter FSM states
//             region_t - decoded target region of an address
//             C_*_DEF  - default parameter values for the 16-bit cpu map
//             clog2_min1() - index width helper that never returns 0
//  Revision : 1.0 - initial release
// ============================================================================
package mem_map_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAM = 2'd1,
      IO   = 2'd2,
      RESP = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      REG_DRAM = 2'd0,
      REG_IO   = 2'd1,
      REG_NONE = 2'd2
   } region_t;

   localparam int          C_AW_DEF        = 16;
   localparam int          C_DW_DEF        = 16;
   localparam int          C_DRAM_AW_DEF   = 25;
   localparam logic [15:0] C_DRAM_LAST_DEF = 16'hF7FF;
   localparam logic [15:0] C_IO_BASE_DEF   = 16'hF800;
   localparam int          C_NUM_IO_DEF    = 8;
   localparam int          C_DRAM_LAT_DEF  = 4;

   // Width of an index able to address n items; a single item still
   // gets a 1-bit index so no zero-width vectors appear.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : mem_map_pkg
`default_nettype wire

// File: rtl/mem_map_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mem_map_decode
//  Purpose  : Combinational address decoder. Classifies a cpu address as
//             DRAM, one of NUM_IO memory-mapped registers, or unmapped.
//  Ports    : addr   in  AW  address to classify
//             region out     REG_DRAM / REG_IO / REG_NONE
//             idx    out IW  I/O register index (addr - IO_BASE), 0 otherwise
//  Revision : 1.0 - initial release
// ============================================================================
module mem_map_decode
   import mem_map_pkg::*;
#(
   parameter int          AW        = C_AW_DEF,
   parameter logic [AW-1:0] DRAM_LAST = C_DRAM_LAST_DEF,
   parameter logic [AW-1:0] IO_BASE   = C_IO_BASE_DEF,
   parameter int          NUM_IO    = C_NUM_IO_DEF,
   parameter int          IW        = clog2_min1(NUM_IO)
) (
   input  logic [AW-1:0] addr,
   output region_t       region,
   output logic [IW-1:0] idx
);

   logic [AW-1:0] w_off;

   always_comb begin
      region = REG_NONE;
      idx    = '0;
      // Offset is only meaningful when addr >= IO_BASE; it is computed
      // unconditionally and used only under that guard.
      w_off  = addr - IO_BASE;
      if (addr <= DRAM_LAST) begin
         region = REG_DRAM;
      end else if ((addr >= IO_BASE) && (32'(w_off) < 32'(NUM_IO))) begin
         region = REG_IO;
         idx    = w_off[IW-1:0];
      end
   end

endmodule : mem_map_decode
`default_nettype wire

// File: rtl/mem_map_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_map_arb
//  Purpose  : Two-requester (instruction fetch / data load-store) arbiter
//             and memory-map decoder. Grants one request at a time onto a
//             single sdram_ctl port or onto NUM_IO memory-mapped registers,
//             and returns read data with a one-cycle ack pulse.
//  Ports    : clk, rst                     clock, synchronous active-high reset
//             if_req/if_addr               fetch request (always a read)
//             if_rdata/if_ack              fetch data and one-cycle completion
//             d_req/d_we/d_addr/d_wdata    data load/store request
//             d_rdata/d_ack                load data and one-cycle completion
//             dram_addr/we/wdata/rdata     sdram_ctl port
//             io_we/io_wdata               one-hot I/O write strobe and data
//             io_rdata                     packed I/O read values (reg i at
//                                          [i*DW +: DW])
//             fault_clr/fault_valid/fault_addr  present only with
//                                          MEM_MAP_FAULT_EN: sticky record of
//                                          the first unmapped access
//  Config   : `define MEM_MAP_FAULT_EN to add the unmapped-access fault ports.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_map_arb
   import mem_map_pkg::*;
#(
   parameter int            AW        = C_AW_DEF,
   parameter int            DW        = C_DW_DEF,
   parameter int            DRAM_AW   = C_DRAM_AW_DEF,
   parameter logic [AW-1:0] DRAM_LAST = C_DRAM_LAST_DEF,
   parameter logic [AW-1:0] IO_BASE   = C_IO_BASE_DEF,
   parameter int            NUM_IO    = C_NUM_IO_DEF,
   parameter int            DRAM_LAT  = C_DRAM_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req,
   input  logic [AW-1:0]        if_addr,
   output logic [DW-1:0]        if_rdata,
   output logic                 if_ack,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [AW-1:0]        d_addr,
   input  logic [DW-1:0]        d_wdata,
   output logic [DW-1:0]        d_rdata,
   output logic                 d_ack,
   output logic [DRAM_AW-1:0]   dram_addr,
   output logic                 dram_we,
   output logic [DW-1:0]        dram_wdata,
   input  logic [DW-1:0]        dram_rdata,
   output logic [NUM_IO-1:0]    io_we,
   output logic [DW-1:0]        io_wdata,
   input  logic [NUM_IO*DW-1:0] io_rdata
`ifdef MEM_MAP_FAULT_EN
   ,
   input  logic                 fault_clr,
   output logic                 fault_valid,
   output logic [AW-1:0]        fault_addr
`endif
);

   localparam int IW = clog2_min1(NUM_IO);
   localparam int CW = clog2_min1(DRAM_LAT);

   // ------------------------------------------------------------------------
   // Elaboration-time sanity checks on the address map
   // ------------------------------------------------------------------------
   if ((NUM_IO < 1) || (NUM_IO > 64)) begin : g_chk_num_io
      $error("mem_map_arb: NUM_IO must be in 1..64");
   end
   if (DRAM_LAT < 1) begin : g_chk_dram_lat
      $error("mem_map_arb: DRAM_LAT must be >= 1");
   end
   if (DRAM_AW < AW) begin : g_chk_dram_aw
      $error("mem_map_arb: DRAM_AW must be >= AW");
   end
   if ((64'(IO_BASE) + 64'(NUM_IO)) > (64'd1 << AW)) begin : g_chk_io_wrap
      $error("mem_map_arb: I/O region wraps past the top of the address space");
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t          state;
   state_t          state_nxt;
   logic            r_pend;      // request latched, decode happens this cycle
   logic            r_gnt_d;     // 1 = data requester owns the access
   logic            r_ptr_d;     // round-robin pointer, 1 = data preferred
   logic [AW-1:0]   r_addr;
   logic            r_we;
   logic [DW-1:0]   r_wdata;
   logic [DW-1:0]   r_rdata;
   logic [CW-1:0]   r_cnt;
   logic            r_io_hit;    // IO state targets a real register
   logic [IW-1:0]   r_idx;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   region_t         w_region;
   logic [IW-1:0]   w_idx;
   logic            w_gnt_d;
   logic            w_gnt_if;
   logic            w_dram_last;
   logic [DW-1:0]   w_io_words [NUM_IO];

   mem_map_decode #(
      .AW        (AW),
      .DRAM_LAST (DRAM_LAST),
      .IO_BASE   (IO_BASE),
      .NUM_IO    (NUM_IO),
      .IW        (IW)
   ) u_decode (
      .addr   (r_addr),
      .region (w_region),
      .idx    (w_idx)
   );

   for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_io_unpack
      assign w_io_words[gi] = io_rdata[gi*DW +: DW];
   end

   // A lone requester always wins; on contention the pointer decides.
   assign w_gnt_d     = d_req  & (~if_req | r_ptr_d);
   assign w_gnt_if    = if_req & (~d_req  | ~r_ptr_d);
   assign w_dram_last = (r_cnt == CW'(DRAM_LAT - 1));

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      dram_addr  = '0;
      dram_we    = 1'b0;
      dram_wdata = '0;
      io_we      = '0;
      io_wdata   = '0;
      if_ack     = 1'b0;
      if_rdata   = '0;
      d_ack      = 1'b0;
      d_rdata    = '0;
      case (state)
         IDLE: begin
            // The cycle after a grant decodes the latched address. Unmapped
            // accesses take the IO slot with no strobe or capture so that
            // their ack timing matches an I/O access.
            if (r_pend) begin
               state_nxt = (w_region == REG_DRAM) ? DRAM : IO;
            end
         end
         DRAM: begin
            dram_addr  = DRAM_AW'(r_addr);
            dram_we    = r_we;
            dram_wdata = r_wdata;
            if (w_dram_last) begin
               state_nxt = RESP;
            end
         end
         IO: begin
            if (r_io_hit && r_we) begin
               io_we    = NUM_IO'(1) << r_idx;
               io_wdata = r_wdata;
            end
            state_nxt = RESP;
         end
         RESP: begin
            if (r_gnt_d) begin
               d_ack   = 1'b1;
               d_rdata = r_rdata;
            end else begin
               if_ack   = 1'b1;
               if_rdata = r_rdata;
            end
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Request latch, DRAM counter and read-data capture
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend   <= 1'b0;
         r_gnt_d  <= 1'b0;
         r_ptr_d  <= 1'b1;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_cnt    <= '0;
         r_io_hit <= 1'b0;
         r_idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (r_pend) begin
                  r_pend   <= 1'b0;
                  r_cnt    <= '0;
                  r_io_hit <= (w_region == REG_IO);
                  r_idx    <= w_idx;
               end else if (w_gnt_d || w_gnt_if) begin
                  r_pend  <= 1'b1;
                  r_gnt_d <= w_gnt_d;
                  r_addr  <= w_gnt_d ? d_addr : if_addr;
                  r_we    <= w_gnt_d & d_we;       // fetch is always a read
                  r_wdata <= w_gnt_d ? d_wdata : '0;
                  r_rdata <= '0;                   // stores/unmapped return 0
                  r_ptr_d <= ~r_ptr_d;
               end
            end
            DRAM: begin
               if (w_dram_last) begin
                  if (!r_we) begin
                     r_rdata <= dram_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            IO: begin
               if (r_io_hit && !r_we) begin
                  r_rdata <= w_io_words[r_idx];
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef MEM_MAP_FAULT_EN
   // ------------------------------------------------------------------------
   // Sticky unmapped-access record. A new fault beats a simultaneous clear,
   // and in that case its address replaces the cleared one.
   // ------------------------------------------------------------------------
   logic w_fault;
   assign w_fault = (state == IDLE) && r_pend && (w_region == REG_NONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_valid <= 1'b0;
         fault_addr  <= '0;
      end else if (w_fault) begin
         fault_valid <= 1'b1;
         if (!fault_valid || fault_clr) begin
            fault_addr <= r_addr;
         end
      end else if (fault_clr) begin
         fault_valid <= 1'b0;
         fault_addr  <= '0;
      end
   end
`endif

endmodule : mem_map_arb
`default_nettype wire

// File: tb/tb_mem_map_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_map_arb
//  Purpose  : Directed self-checking bench for mem_map_arb with default
//             parameters (16-bit map, 8 I/O registers, DRAM_LAT = 4).
//             Builds with or without MEM_MAP_FAULT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_map_arb;

   logic         clk = 1'b0;
   logic         rst;
   logic         if_req;
   logic [15:0]  if_addr;
   logic [15:0]  if_rdata;
   logic         if_ack;
   logic         d_req;
   logic         d_we;
   logic [15:0]  d_addr;
   logic [15:0]  d_wdata;
   logic [15:0]  d_rdata;
   logic         d_ack;
   logic [24:0]  dram_addr;
   logic         dram_we;
   logic [15:0]  dram_wdata;
   logic [15:0]  dram_rdata;
   logic [7:0]   io_we;
   logic [15:0]  io_wdata;
   logic [127:0] io_rdata;
`ifdef MEM_MAP_FAULT_EN
   logic         fault_clr;
   logic         fault_valid;
   logic [15:0]  fault_addr;
`endif

   int checks = 0;
   int errors = 0;

   mem_map_arb dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_ack     (if_ack),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_ack      (d_ack),
      .dram_addr  (dram_addr),
      .dram_we    (dram_we),
      .dram_wdata (dram_wdata),
      .dram_rdata (dram_rdata),
      .io_we      (io_we),
      .io_wdata   (io_wdata),
      .io_rdata   (io_rdata)
`ifdef MEM_MAP_FAULT_EN
      ,
      .fault_clr   (fault_clr),
      .fault_valid (fault_valid),
      .fault_addr  (fault_addr)
`endif
   );

   always #5 clk = ~clk;

   // Activity monitor, sampled mid-cycle.
   int          dram_we_cyc  = 0;
   int          io_we_cyc    = 0;
   int          ack_cyc      = 0;
   int          both_ack_cyc = 0;
   logic [24:0] dram_addr_last  = '0;
   logic [15:0] dram_wdata_last = '0;
   logic [7:0]  io_we_last      = '0;
   logic [15:0] io_wdata_last   = '0;

   always @(negedge clk) begin
      if (dram_we) begin
         dram_we_cyc     = dram_we_cyc + 1;
         dram_addr_last  = dram_addr;
         dram_wdata_last = dram_wdata;
      end
      if (io_we != 8'h00) begin
         io_we_cyc     = io_we_cyc + 1;
         io_we_last    = io_we;
         io_wdata_last = io_wdata;
      end
      if (if_ack || d_ack) ack_cyc = ack_cyc + 1;
      if (if_ack && d_ack) both_ack_cyc = both_ack_cyc + 1;
   end

   // One request from one requester. lat = posedges from the sampling edge
   // to the edge after which ack is high (-1 on timeout). The address and
   // data inputs are scrambled right after the grant edge.
   task automatic access(input bit use_d, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, output int lat,
                         output logic [15:0] rdata);
      @(negedge clk);
      if (use_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      lat   = -1;
      rdata = 16'hDEAD;
      @(posedge clk);
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         if (n == 0) begin
            d_addr = 16'hFFFF; d_wdata = 16'h0BAD; if_addr = 16'hFFFF; d_we = ~d_we;
         end
         if ((use_d && d_ack) || (!use_d && if_ack)) begin
            lat   = n;
            rdata = use_d ? d_rdata : if_rdata;
            break;
         end
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({if_ack, d_ack, dram_we} !== 3'b000) begin
         errors++; $display("FAIL reset_acks_we: got %b expected 000", {if_ack, d_ack, dram_we});
      end
      checks++;
      if (dram_addr !== 25'h0) begin
         errors++; $display("FAIL reset_dram_addr: got %h expected 0", dram_addr);
      end
      checks++;
      if ({io_we, io_wdata, dram_wdata} !== 40'h0) begin
         errors++; $display("FAIL reset_io_outputs: got %h expected 0", {io_we, io_wdata, dram_wdata});
      end
      checks++;
      if ({if_rdata, d_rdata} !== 32'h0) begin
         errors++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
      end
`ifdef MEM_MAP_FAULT_EN
      checks++;
      if ({fault_valid, fault_addr} !== 17'h0) begin
         errors++; $display("FAIL reset_fault: got %h expected 0", {fault_valid, fault_addr});
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_dram_store;
      int lat; logic [15:0] rd; int dw0; int io0;
      dram_rdata = 16'h1234;
      dw0 = dram_we_cyc; io0 = io_we_cyc;
      access(1'b1, 1'b1, 16'h0010, 16'hBEEF, lat, rd);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL dram_store_latency: got %0d expected 5", lat); end
      checks++;
      if (dram_we_cyc - dw0 !== 4) begin
         errors++; $display("FAIL dram_store_we_cycles: got %0d expected 4", dram_we_cyc - dw0);
      end
      checks++;
      if (dram_addr_last !== 25'h10) begin
         errors++; $display("FAIL dram_store_addr: got %h expected 0000010", dram_addr_last);
      end
      checks++;
      if (dram_wdata_last !== 16'hBEEF) begin
         errors++; $display("FAIL dram_store_wdata: got %h expected beef", dram_wdata_last);
      end
      checks++;
      if (rd !== 16'h0000) begin errors++; $display("FAIL dram_store_rdata: got %h expected 0000", rd); end
      checks++;
      if (io_we_cyc - io0 !== 0) begin
         errors++; $display("FAIL dram_store_no_io: got %0d expected 0", io_we_cyc - io0);
      end
   endtask

   task automatic test_fetch_load;
      int lat; logic [15:0] rd; int dw0;
      dram_rdata = 16'hBEEF;
      dw0 = dram_we_cyc;
      access(1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd);
      checks++;
      if (rd !== 16'hBEEF) begin errors++; $display("FAIL fetch_rdata: got %h expected beef", rd); end
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL fetch_latency: got %0d expected 5", lat); end
      checks++;
      if (dram_we_cyc - dw0 !== 0) begin
         errors++; $display("FAIL fetch_dram_we: got %0d expected 0", dram_we_cyc - dw0);
      end
   endtask

   task automatic test_arbitration;
      bit order [4]; int nack; int both0; logic [15:0] drd;
      dram_rdata = 16'h5A5A;
      both0 = both_ack_cyc; nack = 0; drd = 16'h0;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         if_req = 1'b1; if_addr = 16'h0100;
         d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
         for (int n = 0; n < 60 && (if_req || d_req); n++) begin
            @(negedge clk);
            if (d_ack) begin
               if (nack < 4) order[nack] = 1'b1;
               nack++; d_req = 1'b0; drd = d_rdata;
            end
            if (if_ack) begin
               if (nack < 4) order[nack] = 1'b0;
               nack++; if_req = 1'b0;
            end
         end
         if_req = 1'b0; d_req = 1'b0;
      end
      checks++;
      if (nack !== 4) begin errors++; $display("FAIL arb_ack_count: got %0d expected 4", nack); end
      checks++;
      if ({order[0], order[1], order[2], order[3]} !== 4'b1010) begin
         errors++;
         $display("FAIL arb_order: got %b expected 1010 (1=data)", {order[0], order[1], order[2], order[3]});
      end
      checks++;
      if (both_ack_cyc - both0 !== 0) begin
         errors++; $display("FAIL arb_both_acks: got %0d expected 0", both_ack_cyc - both0);
      end
      checks++;
      if (drd !== 16'h5A5A) begin errors++; $display("FAIL arb_d_rdata: got %h expected 5a5a", drd); end
   endtask

   task automatic test_io;
      int lat; logic [15:0] rd; int io0; int dw0;
      io0 = io_we_cyc; dw0 = dram_we_cyc;
      access(1'b1, 1'b1, 16'hF803, 16'h00A5, lat, rd);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL io_store_latency: got %0d expected 2", lat); end
      checks++;
      if (io_we_cyc - io0 !== 1) begin
         errors++; $display("FAIL io_store_we_cycles: got %0d expected 1", io_we_cyc - io0);
      end
      checks++;
      if (io_we_last !== 8'b0000_1000) begin
         errors++; $display("FAIL io_store_we_value: got %b expected 00001000", io_we_last);
      end
      checks++;
      if (io_wdata_last !== 16'h00A5) begin
         errors++; $display("FAIL io_store_wdata: got %h expected 00a5", io_wdata_last);
      end
      checks++;
      if (dram_we_cyc - dw0 !== 0) begin
         errors++; $display("FAIL io_store_no_dram: got %0d expected 0", dram_we_cyc - dw0);
      end
      access(1'b1, 1'b0, 16'hF803, 16'h0000, lat, rd);
      checks++;
      if (rd !== 16'h4444) begin errors++; $display("FAIL io_load_reg3: got %h expected 4444", rd); end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL io_load_latency: got %0d expected 2", lat); end
      access(1'b1, 1'b0, 16'hF807, 16'h0000, lat, rd);
      checks++;
      if (rd !== 16'h8888) begin errors++; $display("FAIL io_load_last_reg: got %h expected 8888", rd); end
      access(1'b0, 1'b0, 16'hF800, 16'h0000, lat, rd);
      checks++;
      if (rd !== 16'h1111) begin errors++; $display("FAIL io_fetch_reg0: got %h expected 1111", rd); end
   endtask

   task automatic test_unmapped;
      int lat; logic [15:0] rd; int io0; int dw0;
      io0 = io_we_cyc; dw0 = dram_we_cyc;
      access(1'b1, 1'b0, 16'hF900, 16'h0000, lat, rd);
      checks++;
      if (rd !== 16'h0000) begin errors++; $display("FAIL unmapped_rdata: got %h expected 0000", rd); end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL unmapped_latency: got %0d expected 2", lat); end
      checks++;
      if ((dram_we_cyc - dw0) + (io_we_cyc - io0) !== 0) begin
         errors++;
         $display("FAIL unmapped_side_effects: got %0d expected 0", (dram_we_cyc - dw0) + (io_we_cyc - io0));
      end
`ifdef MEM_MAP_FAULT_EN
      checks++;
      if ({fault_valid, fault_addr} !== {1'b1, 16'hF900}) begin
         errors++; $display("FAIL fault_first: got %b/%h expected 1/f900", fault_valid, fault_addr);
      end
`endif
      // One past the last I/O register: unmapped store, nothing written.
      io0 = io_we_cyc;
      access(1'b1, 1'b1, 16'hF808, 16'h1357, lat, rd);
      checks++;
      if ((io_we_cyc - io0) !== 0 || lat !== 2) begin
         errors++; $display("FAIL unmapped_past_io: got io_we=%0d lat=%0d expected 0/2", io_we_cyc - io0, lat);
      end
`ifdef MEM_MAP_FAULT_EN
      checks++;
      if (fault_addr !== 16'hF900) begin
         errors++; $display("FAIL fault_sticky_addr: got %h expected f900", fault_addr);
      end
      @(negedge clk); fault_clr = 1'b1;
      @(negedge clk); fault_clr = 1'b0;
      checks++;
      if ({fault_valid, fault_addr} !== 17'h0) begin
         errors++; $display("FAIL fault_clear: got %b/%h expected 0/0000", fault_valid, fault_addr);
      end
`endif
      // Last DRAM address still goes to DRAM.
      dram_rdata = 16'h0F0F;
      access(1'b1, 1'b0, 16'hF7FF, 16'h0000, lat, rd);
      checks++;
      if (rd !== 16'h0F0F || lat !== 5) begin
         errors++; $display("FAIL dram_last_addr: got %h lat %0d expected 0f0f lat 5", rd, lat);
      end
   endtask

   task automatic test_reset_mid_access;
      int ack0; int dw0; int lat; logic [15:0] rd;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h7777;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (dram_we !== 1'b1) begin errors++; $display("FAIL mid_store_active: got %b expected 1", dram_we); end
      rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      checks++;
      if ({dram_we, d_ack, if_ack} !== 3'b000 || dram_addr !== 25'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got we/ack/addr %b/%b/%h expected 0/0/0", dram_we, d_ack, dram_addr);
      end
      rst  = 1'b0;
      ack0 = ack_cyc; dw0 = dram_we_cyc;
      repeat (10) @(negedge clk);
      checks++;
      if (ack_cyc - ack0 !== 0) begin
         errors++; $display("FAIL mid_reset_no_ack: got %0d expected 0", ack_cyc - ack0);
      end
      checks++;
      if (dram_we_cyc - dw0 !== 0) begin
         errors++; $display("FAIL mid_reset_no_dram_we: got %0d expected 0", dram_we_cyc - dw0);
      end
      access(1'b1, 1'b0, 16'hF802, 16'h0000, lat, rd);
      checks++;
      if (rd !== 16'h3333 || lat !== 2) begin
         errors++; $display("FAIL mid_reset_idle: got %h lat %0d expected 3333 lat 2", rd, lat);
      end
   endtask

   initial begin
      logic [15:0] word;
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      dram_rdata = '0;
`ifdef MEM_MAP_FAULT_EN
      fault_clr = 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
         word = 16'(16'h1111 * (i + 1));
         io_rdata[i*16 +: 16] = word;
      end
      test_reset;
      test_dram_store;
      test_fetch_load;
      test_arbitration;
      test_io;
      test_unmapped;
      test_reset_mid_access;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_map_arb
`default_nettype wire
